// File: rtl/arb_waveform_loader.sv
// ============================================================================
// Module      : arb_waveform_loader
// Description : Writer side of the ping-pong arbitrary-waveform table. Loads a
//               sample stream into the shadow bank, zero-pads the remaining
//               entries and then swaps banks in a single cycle, so the
//               generator never reads a half-written table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_waveform_loader #(
  parameter int ARB_WAVEFORM_DEPTH = 1024,
  parameter int ADDR_W             = $clog2(ARB_WAVEFORM_DEPTH),
  parameter int DATA_W             = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W:0]   i_cmd_len,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_last,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_active_bank,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_err
);

  localparam logic [ADDR_W:0] C_DEPTH    = (ADDR_W+1)'(ARB_WAVEFORM_DEPTH);
  localparam logic [ADDR_W:0] C_LAST_IDX = C_DEPTH - (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] C_ONE      = (ADDR_W+1)'(1);

  localparam logic [1:0] C_ERR_OK    = 2'd0;
  localparam logic [1:0] C_ERR_SHORT = 2'd1;
  localparam logic [1:0] C_ERR_LONG  = 2'd2;
  localparam logic [1:0] C_ERR_LEN   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DRAIN  = 3'd2,
    S_PAD    = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_wr_ptr;
  logic                r_active_bank;
  logic                r_done;
  logic [1:0]          r_err;
  logic [DATA_W-1:0]   r_rd_data;

  // Both banks live in one array; the MSB of the index selects the bank.
  logic [DATA_W-1:0]   r_mem [0:2*ARB_WAVEFORM_DEPTH-1];

  logic                w_len_ok;
  logic                w_final_beat;
  logic                w_wr_en;
  logic [ADDR_W:0]     w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;

  assign w_len_ok     = (i_cmd_len != '0) && (i_cmd_len <= C_DEPTH);
  assign w_final_beat = ((r_wr_ptr + C_ONE) == r_len);

  // Writes always target the shadow bank; a reset edge never writes.
  assign w_wr_en   = rst_n && (((r_state == S_LOAD) && i_s_valid) || (r_state == S_PAD));
  assign w_wr_addr = {~r_active_bank, r_wr_ptr[ADDR_W-1:0]};
  assign w_wr_data = (r_state == S_PAD) ? '0 : i_s_data;

  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_s_ready     = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_active_bank = r_active_bank;
  assign o_rd_data     = r_rd_data;

  // Load sequencer: command accept, streaming, drain on overrun, pad and swap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_wr_ptr      <= '0;
      r_active_bank <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= C_ERR_OK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            if (w_len_ok) begin
              r_state  <= S_LOAD;
              r_len    <= i_cmd_len;
              r_wr_ptr <= '0;
              r_err    <= C_ERR_OK;
            end else begin
              r_err <= C_ERR_LEN;
            end
          end
        end
        S_LOAD: begin
          if (i_s_valid) begin
            r_wr_ptr <= r_wr_ptr + C_ONE;
            if (w_final_beat) begin
              if (i_s_last) begin
                r_state <= (r_len == C_DEPTH) ? S_COMMIT : S_PAD;
              end else begin
                r_err   <= C_ERR_LONG;
                r_state <= S_DRAIN;
              end
            end else if (i_s_last) begin
              r_err   <= C_ERR_SHORT;
              r_state <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (i_s_valid && i_s_last) begin
            r_state <= S_IDLE;
          end
        end
        S_PAD: begin
          r_wr_ptr <= r_wr_ptr + C_ONE;
          if (r_wr_ptr == C_LAST_IDX) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_active_bank <= ~r_active_bank;
          r_done        <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Shadow-bank write port; table contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Generator read port; uses the bank selection as it stood before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[{r_active_bank, i_rd_addr}];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arb_waveform_loader.sv
// ============================================================================
// Module      : tb_arb_waveform_loader
// Description : Self-checking bench for arb_waveform_loader. A table-level
//               model predicts the active bank contents, bank swaps and done
//               pulses; directed tests pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_arb_waveform_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 16;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW:0]   cmd_len;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          active_bank;
  logic          busy;
  logic          done;
  logic [1:0]    err;

  arb_waveform_loader #(
    .ARB_WAVEFORM_DEPTH(DEPTH),
    .ADDR_W            (AW),
    .DATA_W            (DW)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_len    (cmd_len),
    .i_s_valid    (s_valid),
    .o_s_ready    (s_ready),
    .i_s_data     (s_data),
    .i_s_last     (s_last),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_active_bank(active_bank),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Table model: expected contents per bank, which bank is live, and the
  // clock edge at which the pending swap must become visible.
  logic [DW-1:0] m_tbl [2][DEPTH];
  bit            m_valid [2];
  bit            m_active;
  int            m_done_edge = -1;
  logic [DW-1:0] bt [DEPTH];

  bit            sweep_en;
  logic [AW-1:0] sweep_addr;
  bit            p_have;
  bit            p_rst_n;
  logic [AW-1:0] p_rd_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model; also drives the read address.
  initial begin
    p_have   = 1'b0;
    m_active = 1'b0;
    m_valid  = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      if (p_have) begin
        if (!p_rst_n) begin
          check("rst_rd_data", rd_data, 0);
          check("rst_done", done, 0);
          check("rst_active", active_bank, 0);
          m_active    = 1'b0;
          m_valid     = '{1'b0, 1'b0};
          m_done_edge = -1;
        end else begin
          if (m_valid[m_active]) check("rd_data", rd_data, m_tbl[m_active][p_rd_addr]);
          check("done", done, (cyc == m_done_edge));
          if (cyc == m_done_edge) begin
            m_active          = !m_active;
            m_valid[m_active] = 1'b1;
            m_done_edge       = -1;
          end
          check("active_bank", active_bank, m_active);
        end
      end
      p_have    = 1'b1;
      p_rst_n   = rst_n;
      rd_addr   = sweep_en ? sweep_addr : AW'($urandom_range(0, DEPTH-1));
      p_rd_addr = rd_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command; returns how many cycles it waited for cmd_ready.
  task automatic do_cmd(input int len, output int waits);
    bit ok;
    ok        = 1'b0;
    waits     = 0;
    cmd_valid = 1'b1;
    cmd_len   = (AW+1)'(len);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) check("cmd_handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Send one beat; returns the clock edge number of the handshake.
  task automatic send_beat(input logic [DW-1:0] d, input bit last, output int edge_n);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("beat_handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
    edge_n  = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(output int edge_n);
    bit ok;
    ok     = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        ok     = 1'b1;
        edge_n = cyc;
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
    tick();
  endtask

  // Expected shadow contents after a good load: samples then zeros.
  task automatic model_load(input int len, input int last_edge);
    for (int i = 0; i < DEPTH; i++) m_tbl[int'(!m_active)][i] = (i < len) ? bt[i] : '0;
    m_done_edge = last_edge + (DEPTH - len) + 1;
  endtask

  task automatic rd_check(input string name, input int addr, input logic [DW-1:0] exp);
    sweep_en   = 1'b1;
    sweep_addr = AW'(addr);
    tick();
    check(name, rd_data, exp);
    sweep_en = 1'b0;
  endtask

  initial begin
    int e, f, d, w;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    sweep_en = 1'b0; sweep_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("reset_active", active_bank, 0);
    check("reset_err", err, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_s_ready", s_ready, 0);
    check("reset_rd_data", rd_data, 0);

    // Short load with padding
    do_cmd(4, w);
    check("t1_busy", busy, 1);
    bt[0] = 16'h0001; bt[1] = 16'h0002; bt[2] = 16'h0003; bt[3] = 16'h7FFF;
    f = 0;
    for (int i = 0; i < 4; i++) begin
      send_beat(bt[i], (i == 3), e);
      if (i == 0) f = e;
    end
    model_load(4, e);
    s_valid = 1'b1; s_data = 16'hDEAD; s_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_pad_s_ready", s_ready, 0);
    end
    check("t1_pad_cmd_ready", cmd_ready, 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    wait_done(d);
    check("t1_done_latency", d - f, 1024);
    check("t1_active", active_bank, 1);
    check("t1_err", err, 0);
    rd_check("t1_rd0", 0, 16'h0001);
    rd_check("t1_rd1", 1, 16'h0002);
    rd_check("t1_rd2", 2, 16'h0003);
    rd_check("t1_rd3", 3, 16'h7FFF);
    rd_check("t1_rd4", 4, 16'h0000);
    rd_check("t1_rd700", 700, 16'h0000);
    rd_check("t1_rd1023", 1023, 16'h0000);

    // Full-depth load with random valid gaps
    do_cmd(1024, w);
    for (int i = 0; i < DEPTH; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      bt[i] = 16'(i * 40503 + 17);
      send_beat(bt[i], (i == DEPTH-1), e);
    end
    model_load(1024, e);
    wait_done(d);
    check("t2_no_pad", d - e, 1);
    check("t2_active", active_bank, 0);
    check("t2_err", err, 0);
    rd_check("t2_rd1023", 1023, 16'(1023 * 40503 + 17));
    rd_check("t2_rd0", 0, 16'h0011);

    // Stream ends early
    do_cmd(8, w);
    send_beat(16'hAAAA, 1'b0, e);
    send_beat(16'hBBBB, 1'b0, e);
    send_beat(16'hCCCC, 1'b1, e);
    repeat (3) tick();
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_active", active_bank, 0);
    rd_check("t3_rd0_old", 0, 16'h0011);
    rd_check("t3_rd2_old", 2, 16'(2 * 40503 + 17));

    // Stream overruns
    do_cmd(2, w);
    check("t4_err_cleared", err, 0);
    send_beat(16'h1111, 1'b0, e);
    send_beat(16'h2222, 1'b0, e);
    send_beat(16'h3333, 1'b0, e);
    check("t4_err_drain", err, 2);
    check("t4_busy_drain", busy, 1);
    send_beat(16'h4444, 1'b0, e);
    send_beat(16'h5555, 1'b1, e);
    tick();
    check("t4_busy", busy, 0);
    check("t4_err", err, 2);
    check("t4_active", active_bank, 0);
    rd_check("t4_rd1_old", 1, 16'(40503 + 17));

    // Illegal lengths
    do_cmd(0, w);
    check("t5_len0_wait", w, 0);
    check("t5_len0_err", err, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_len0_busy", busy, 0);
    end
    tick();
    do_cmd(1025, w);
    check("t5_len1025_wait", w, 0);
    check("t5_len1025_err", err, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_len1025_busy", busy, 0);
    end
    tick();
    check("t5_active", active_bank, 0);

    // Reset during a load, then a clean load
    do_cmd(16, w);
    for (int i = 0; i < 5; i++) send_beat(16'hBEEF, 1'b0, e);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_active", active_bank, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_busy", busy, 0);
    do_cmd(16, w);
    for (int i = 0; i < 16; i++) begin
      bt[i] = 16'h1000 + 16'(i);
      send_beat(bt[i], (i == 15), e);
    end
    model_load(16, e);
    wait_done(d);
    check("t6_active", active_bank, 1);
    check("t6_err", err, 0);
    rd_check("t6_rd15", 15, 16'h100F);
    rd_check("t6_rd16", 16, 16'h0000);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
